vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Upstream timing stage for the on-screen text/logo renderer.
- Divides the system clock down to a pixel-enable tick and runs the horizontal and vertical pixel counters.
- Drives the `pixel_x`/`pixel_y` coordinates consumed by the text renderer's `pix_x`/`pix_y` inputs.
- Generates the VGA `hsync`/`vsync` signals and the `video_on` blanking qualifier for the RGB output mux.

Parameters:
- TICK_DIV, 4, system clocks per pixel; must be ≥2 (100 MHz → 25 MHz).
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_DISP, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p_tick  out  1  pixel enable; one clk wide, every TICK_DIV clks
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frame_end  out  1  one clk pulse on the tick that wraps the frame

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; elaboration fails otherwise.
- Reset values: tick counter 0, p_tick 0, pixel_x 0, pixel_y 0, hsync 1, vsync 1, frame_end 0. video_on is 1 immediately after reset, since it is derived from the zero counts.
- Tick divider:
  - Mod-TICK_DIV counter.
  - p_tick is registered and high for the single clk in which the counter equals TICK_DIV-1.
  - First p_tick occurs TICK_DIV clks after reset deasserts.
- Horizontal counter:
  - Advances only on clks where p_tick=1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Advances only when p_tick=1 and pixel_x=H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0.
- Sync and frame outputs:
  - hsync, vsync and frame_end are registered from the next-state counts, so they are cycle-aligned with pixel_x/pixel_y. There is no extra latency between coordinates and sync.
  - hsync = 0 iff pixel_x ∈ [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1], i.e. [656,751].
  - vsync = 0 iff pixel_y ∈ [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1], i.e. [490,491].
  - frame_end = 1 for the one clk in which the coordinates change from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- video_on: combinational, (pixel_x < H_DISP) && (pixel_y < V_DISP).
- Hold between ticks: coordinates and syncs hold steady for all TICK_DIV clks between ticks.
- Reset mid-frame: on the next clk all outputs return to their reset values. There is no partial-line completion. A reset asserted simultaneously with p_tick takes priority.
- Downstream registered stages may rely on the coordinates being stable for ≥TICK_DIV-1 clks. This covers the renderer's one-clk font ROM read.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - Adds output `frame_cnt` (out, 8 bits). Reset value 0.
  - Increments by 1 on each clk where frame_end=1; wraps 255→0.
  - Intended for blink/animation of the initials.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package `vga_timing_pkg`:
  - Default timing constants for 640x480@60.
  - H_TOTAL/V_TOTAL computation functions.
  - Coordinate width constant (10).
- Sub-module `vga_tick_div`:
  - Parameter TICK_DIV.
  - Ports: clk, reset, p_tick.
  - Instantiated once.
- The counters and sync decode stay in `vga_sync_gen`.

Test Plan:
1. Reset held 5 clks, then released → p_tick first high on clk 4 after release; pixel_x 0→1 on that clk; hsync=vsync=1; video_on=1.
2. Run one line (3200 clks) → pixel_x sequence 0..799, then 0; pixel_y increments 0→1 exactly at the wrap; hsync low for exactly 96 ticks starting at pixel_x=656.
3. Run a full frame (1,680,000 clks) → vsync low for exactly 2 lines (y=490,491); frame_end pulses once, 1 clk wide, coordinates return to (0,0).
4. Sample video_on at (639,479)=1, (640,479)=0, (0,480)=0, (799,524)=0.
5. Assert reset at pixel (700,300) coincident with p_tick → next clk pixel_x=0, pixel_y=0, hsync=1, p_tick=0.
6. With VGA_FRAME_CNT_EN defined, run 257 frames → frame_cnt reads 1 after the 257th frame_end (wrap verified).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, coordinate width and frame total helpers.
package vga_timing_pkg;
   localparam int COORD_W    = 10;
   localparam int TICK_DIV_D = 4;
   localparam int H_DISP_D   = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_DISP_D   = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   function automatic int h_total(int disp, int fp, int sync, int bp);
      return disp + fp + sync + bp;
   endfunction
   function automatic int v_total(int disp, int fp, int sync, int bp);
      return disp + fp + sync + bp;
   endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the sync generator to the renderer.
//   p_tick     pixel enable, one clk wide every TICK_DIV clks
//   pixel_x/y  current column / line
//   video_on   visible-area qualifier
//   hsync/vsync active-low syncs
//   frame_end  one clk pulse when the frame wraps
//   frame_cnt  8-bit frame counter (only with VGA_FRAME_CNT_EN)
interface vga_sync_gen_if;
   import vga_timing_pkg::*;
   logic               p_tick;
   logic [COORD_W-1:0] pixel_x;
   logic [COORD_W-1:0] pixel_y;
   logic               video_on;
   logic               hsync;
   logic               vsync;
   logic               frame_end;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0]         frame_cnt;
   modport master(output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end, frame_cnt);
   modport slave(input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end, frame_cnt);
`else
   modport master(output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end);
   modport slave(input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end);
`endif
endinterface

// File: rtl/vga_tick_div.sv
// vga_tick_div: mod-TICK_DIV divider producing a registered one-clk pixel tick.
//   clk, reset  system clock, synchronous active-high reset
//   p_tick      high for one clk every TICK_DIV clks, first TICK_DIV clks after reset
module vga_tick_div #(
   parameter int TICK_DIV = 4
)(
   input  logic clk,
   input  logic reset,
   output logic p_tick
);
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (reset) begin
         cnt    <= '0;
         p_tick <= 1'b0;
      end else begin
         cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
         p_tick <= cnt == LAST;
      end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel tick, h/v counters, active-low syncs, video_on and frame_end for VGA timing.
//   clk, reset  system clock, synchronous active-high reset
//   vga         vga_sync_gen_if.master: p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end
//               (+ frame_cnt when VGA_FRAME_CNT_EN is defined)
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_D,
   parameter int H_DISP   = H_DISP_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_DISP   = V_DISP_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
)(
   input logic            clk,
   input logic            reset,
   vga_sync_gen_if.master vga
);
   localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_TOTAL - 1);
   localparam int HS_LO = H_DISP + H_FP;
   localparam int HS_HI = H_DISP + H_FP + H_SYNC - 1;
   localparam int VS_LO = V_DISP + V_FP;
   localparam int VS_HI = V_DISP + V_FP + V_SYNC - 1;
   if (H_TOTAL > 1024 || V_TOTAL > 1024 || TICK_DIV < 2) begin : g_bad_cfg
      $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024 and TICK_DIV >= 2");
   end
   logic               p_tick;
   logic               line_end;
   logic [COORD_W-1:0] x_next;
   logic [COORD_W-1:0] y_next;
   vga_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );
   assign vga.p_tick   = p_tick;
   assign vga.video_on = int'(vga.pixel_x) < H_DISP && int'(vga.pixel_y) < V_DISP;
   always_comb begin
      line_end = vga.pixel_x == X_MAX;
      x_next   = !p_tick ? vga.pixel_x : line_end ? '0 : vga.pixel_x + 1'b1;
      y_next   = !(p_tick && line_end) ? vga.pixel_y : (vga.pixel_y == Y_MAX) ? '0 : vga.pixel_y + 1'b1;
   end
   // Syncs decode the next-state counts so they change on the same clk as the coordinates.
   always_ff @(posedge clk)
      if (reset) begin
         vga.pixel_x   <= '0;
         vga.pixel_y   <= '0;
         vga.hsync     <= 1'b1;
         vga.vsync     <= 1'b1;
         vga.frame_end <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
         vga.frame_cnt <= '0;
`endif
      end else begin
         vga.pixel_x   <= x_next;
         vga.pixel_y   <= y_next;
         vga.hsync     <= !(int'(x_next) >= HS_LO && int'(x_next) <= HS_HI);
         vga.vsync     <= !(int'(y_next) >= VS_LO && int'(y_next) <= VS_HI);
         vga.frame_end <= p_tick && line_end && vga.pixel_y == Y_MAX;
`ifdef VGA_FRAME_CNT_EN
         vga.frame_cnt <= vga.frame_cnt + 8'(vga.frame_end);
`endif
      end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen on a reduced timing so full frames fit the cycle budget.
module tb_vga_sync_gen;
   localparam int TD = 2;
   localparam int HD = 6, HF = 2, HS = 3, HB = 2;
   localparam int VD = 4, VF = 2, VS = 2, VB = 2;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int F  = HT * VT;
   typedef struct packed {
      logic       p_tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       video_on;
      logic       hsync;
      logic       vsync;
      logic       frame_end;
      logic [7:0] fc;
   } out_t;
   typedef struct {
      int   k;
      out_t e;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   k = 0;
   int   vectors = 0;
   int   miscompares = 0;
   vec_t tbl[$];
   vga_sync_gen_if vif();
   vga_sync_gen #(
      .TICK_DIV(TD), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vga   (vif)
   );
   always #5 clk = ~clk;
   // k = clk edges since reset was released; the frame position is just elapsed ticks mod F.
   function automatic int ticks(int kk);
      return kk > 0 ? (kk - 1) / TD : 0;
   endfunction
   function automatic out_t model(int kk);
      out_t e;
      int t, p, x, y;
      t = ticks(kk);
      p = t % F;
      x = p % HT;
      y = p / HT;
      e.p_tick    = kk > 0 && kk % TD == 0;
      e.x         = 10'(x);
      e.y         = 10'(y);
      e.video_on  = x < HD && y < VD;
      e.hsync     = !(x >= HD + HF && x < HD + HF + HS);
      e.vsync     = !(y >= VD + VF && y < VD + VF + VS);
      e.frame_end = kk > 0 && (kk - 1) % TD == 0 && t > 0 && p == 0;
`ifdef VGA_FRAME_CNT_EN
      e.fc        = 8'(ticks(kk - 1) / F);
`else
      e.fc        = 8'd0;
`endif
      return e;
   endfunction
   function automatic out_t sample();
      out_t s;
      s.p_tick    = vif.p_tick;
      s.x         = vif.pixel_x;
      s.y         = vif.pixel_y;
      s.video_on  = vif.video_on;
      s.hsync     = vif.hsync;
      s.vsync     = vif.vsync;
      s.frame_end = vif.frame_end;
`ifdef VGA_FRAME_CNT_EN
      s.fc        = vif.frame_cnt;
`else
      s.fc        = 8'd0;
`endif
      return s;
   endfunction
   function automatic vec_t mk(int kk, logic p, int x, int y, logic v, logic h, logic vs_, logic fe);
      vec_t r;
      r.k = kk;
      r.e = '{p, 10'(x), 10'(y), v, h, vs_, fe, 8'd0};
      return r;
   endfunction
   task automatic step();
      logic r;
      r = reset;
      @(posedge clk);
      k = r ? 0 : k + 1;
      #1;
   endtask
   task automatic check(string name, out_t e);
      out_t s;
      s = sample();
      vectors++;
      if (s !== e) begin
         miscompares++;
         $display("FAIL %s k=%0d got tick=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fe=%0b fc=%0d exp tick=%0b x=%0d y=%0d von=%0b hs=%0b vs=%0b fe=%0b fc=%0d",
                  name, k, s.p_tick, s.x, s.y, s.video_on, s.hsync, s.vsync, s.frame_end, s.fc,
                  e.p_tick, e.x, e.y, e.video_on, e.hsync, e.vsync, e.frame_end, e.fc);
      end
   endtask
   task automatic cmp_int(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask
   task automatic run(int n);
      for (int i = 0; i < n; i++) begin
         step();
         check("model", model(k));
      end
   endtask
   initial begin
      int hs_low, vs_low, fe_cnt, n, rst_left;
      //            k   tick x   y  von hs vs fe
      tbl.push_back(mk(0,   0, 0,  0, 1, 1, 1, 0));
      tbl.push_back(mk(1,   0, 0,  0, 1, 1, 1, 0));
      tbl.push_back(mk(2,   1, 0,  0, 1, 1, 1, 0));
      tbl.push_back(mk(3,   0, 1,  0, 1, 1, 1, 0));
      tbl.push_back(mk(11,  0, 5,  0, 1, 1, 1, 0));
      tbl.push_back(mk(13,  0, 6,  0, 0, 1, 1, 0));
      tbl.push_back(mk(17,  0, 8,  0, 0, 0, 1, 0));
      tbl.push_back(mk(21,  0, 10, 0, 0, 0, 1, 0));
      tbl.push_back(mk(23,  0, 11, 0, 0, 1, 1, 0));
      tbl.push_back(mk(25,  0, 12, 0, 0, 1, 1, 0));
      tbl.push_back(mk(27,  0, 0,  1, 1, 1, 1, 0));
      tbl.push_back(mk(89,  0, 5,  3, 1, 1, 1, 0));
      tbl.push_back(mk(105, 0, 0,  4, 0, 1, 1, 0));
      tbl.push_back(mk(157, 0, 0,  6, 0, 1, 0, 0));
      tbl.push_back(mk(207, 0, 12, 7, 0, 1, 0, 0));
      tbl.push_back(mk(209, 0, 0,  8, 0, 1, 1, 0));
      tbl.push_back(mk(259, 0, 12, 9, 0, 1, 1, 0));
      tbl.push_back(mk(261, 0, 0,  0, 1, 1, 1, 1));
      tbl.push_back(mk(262, 1, 0,  0, 1, 1, 1, 0));
      reset = 1'b1;
      repeat (5) step();
      check("reset", tbl[0].e);
      reset = 1'b0;
      for (int i = 1; i < tbl.size(); i++) begin
         while (k < tbl[i].k) step();
         check("table", tbl[i].e);
      end
      hs_low = 0;
      vs_low = 0;
      fe_cnt = 0;
      for (int i = 0; i < F * TD - 1; i++) begin
         step();
         check("frame", model(k));
         hs_low += int'(!vif.hsync);
         vs_low += int'(!vif.vsync);
         fe_cnt += int'(vif.frame_end);
      end
      cmp_int("hsync_low_clks", hs_low, HS * TD * VT);
      cmp_int("vsync_low_clks", vs_low, VS * TD * HT);
      cmp_int("frame_end_clks", fe_cnt, 1);
      cmp_int("wrap_x", int'(vif.pixel_x), 0);
      cmp_int("wrap_y", int'(vif.pixel_y), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      run(154);
      cmp_int("pre_reset_tick", int'(vif.p_tick), 1);
      cmp_int("pre_reset_x", int'(vif.pixel_x), 11);
      cmp_int("pre_reset_y", int'(vif.pixel_y), 5);
      reset = 1'b1;
      step();
      check("reset_on_tick", mk(0, 0, 0, 0, 1, 1, 1, 0).e);
      reset = 1'b0;
      rst_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (rst_left == 0 && $urandom_range(199) == 0) rst_left = $urandom_range(3, 1);
         reset = rst_left > 0;
         if (rst_left > 0) rst_left--;
         step();
         check("random", model(k));
      end
      reset = 1'b0;
`ifdef VGA_FRAME_CNT_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      fe_cnt = 0;
      n = 0;
      while (fe_cnt < 257 && n < 257 * F * TD + 100) begin
         step();
         check("frame_cnt_run", model(k));
         fe_cnt += int'(vif.frame_end);
         n++;
      end
      cmp_int("frame_end_count", fe_cnt, 257);
      step();
      cmp_int("frame_cnt_wrap", int'(vif.frame_cnt), 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
